axi_read_protocol: RTL and testbench

//  Read-direction companion to the write-channel (AW/W/B) protocol FSM.

---
 rtl/axi_read_protocol.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_axi_read_protocol.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_read_protocol.sv
// rtl/axi_read_protocol.sv - AXI4 AR/R channel handshake FSMs with burst beat and address tracking
// One outstanding read burst; every output is registered and lags its input by one cycle.
module axi_read_protocol #(
    parameter int AW = 32,
    parameter int DW = 64
) (
    input  logic          axi_aclk,
    input  logic          rst,
    input  logic [AW-1:0] araddr_in,
    input  logic [7:0]    arlen_in,
    input  logic [2:0]    arsize_in,
    input  logic [1:0]    arburst_in,
    input  logic          arvalid_in,
    input  logic          arready_in,
    input  logic [DW-1:0] rdata_in,
    input  logic [1:0]    rresp_in,
    input  logic          rvalid_in,
    input  logic          rready_in,
    output logic [AW-1:0] axi_araddr,
    output logic [7:0]    axi_arlen,
    output logic [2:0]    axi_arsize,
    output logic [1:0]    axi_arburst,
    output logic          axi_arvalid,
    output logic          axi_arready,
    output logic [DW-1:0] axi_rdata,
    output logic [1:0]    axi_rresp,
    output logic          axi_rlast,
    output logic          axi_rvalid,
    output logic          axi_rready,
    output logic [AW-1:0] beat_addr,
    output logic          r_active,
    output logic          err_orphan_r
);

    typedef enum logic [1:0] {
        ST_WAIT   = 2'b00,
        ST_COMMIT = 2'b01,
        ST_ASSERT = 2'b10
    } state_e;

    state_e        ar_st_q, ar_st_d;
    state_e        r_st_q, r_st_d;

    logic [AW-1:0] araddr_q, araddr_d;
    logic [7:0]    arlen_q, arlen_d;
    logic [2:0]    arsize_q, arsize_d;
    logic [1:0]    arburst_q, arburst_d;
    logic          arvalid_q, arvalid_d;
    logic          arready_q, arready_d;

    logic [DW-1:0] rdata_q, rdata_d;
    logic [1:0]    rresp_q, rresp_d;
    logic          rlast_q, rlast_d;
    logic          rvalid_q, rvalid_d;
    logic          rready_q, rready_d;

    // Burst shape is copied out of the AR payload at commit, since the AR
    // payload registers may already hold the next request during the burst.
    logic [7:0]    bst_len_q, bst_len_d;
    logic [2:0]    bst_size_q, bst_size_d;
    logic [1:0]    bst_type_q, bst_type_d;
    logic [7:0]    beat_cnt_q, beat_cnt_d;
    logic [AW-1:0] beat_addr_q, beat_addr_d;
    logic          r_active_q, r_active_d;
    logic          err_q, err_d;

    function automatic logic [AW-1:0] next_addr(
        input logic [AW-1:0] addr,
        input logic [7:0]    len,
        input logic [2:0]    size,
        input logic [1:0]    btype
    );
        logic [AW-1:0] sb;
        logic [AW-1:0] lb;
        logic [AW-1:0] res;
        sb = AW'(1) << size;
        lb = (AW'(len) + AW'(1)) << size;
        case (btype)
            2'b00:   res = addr;
            2'b10:   res = (addr & ~(lb - AW'(1))) | ((addr + sb) & (lb - AW'(1)));
            default: res = addr + sb;
        endcase
        return res;
    endfunction

    always_comb begin
        ar_st_d   = ar_st_q;
        araddr_d  = araddr_q;
        arlen_d   = arlen_q;
        arsize_d  = arsize_q;
        arburst_d = arburst_q;
        arvalid_d = arvalid_q;
        arready_d = arready_q;
        case (ar_st_q)
            ST_WAIT: begin
                if (arvalid_in) begin
                    araddr_d  = araddr_in;
                    arlen_d   = arlen_in;
                    arsize_d  = arsize_in;
                    arburst_d = arburst_in;
                    arvalid_d = 1'b1;
                    if (arready_in && !r_active_q) begin
                        arready_d = 1'b1;
                        ar_st_d   = ST_COMMIT;
                    end else begin
                        arready_d = 1'b0;
                        ar_st_d   = ST_ASSERT;
                    end
                end
            end
            ST_ASSERT: begin
                if (arready_in && !r_active_q) begin
                    arready_d = 1'b1;
                    ar_st_d   = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                arready_d = 1'b0;
                if (arvalid_in) begin
                    araddr_d  = araddr_in;
                    arlen_d   = arlen_in;
                    arsize_d  = arsize_in;
                    arburst_d = arburst_in;
                    arvalid_d = 1'b1;
                    ar_st_d   = ST_ASSERT;
                end else begin
                    arvalid_d = 1'b0;
                    ar_st_d   = ST_WAIT;
                end
            end
            default: begin
                arvalid_d = 1'b0;
                arready_d = 1'b0;
                ar_st_d   = ST_WAIT;
            end
        endcase
    end

    always_comb begin
        r_st_d      = r_st_q;
        rdata_d     = rdata_q;
        rresp_d     = rresp_q;
        rlast_d     = rlast_q;
        rvalid_d    = rvalid_q;
        rready_d    = rready_q;
        bst_len_d   = bst_len_q;
        bst_size_d  = bst_size_q;
        bst_type_d  = bst_type_q;
        beat_cnt_d  = beat_cnt_q;
        beat_addr_d = beat_addr_q;
        r_active_d  = r_active_q;
        err_d       = err_q;

        // AR commit only happens while r_active is low, so it never meets an R commit.
        if (ar_st_q == ST_COMMIT) begin
            r_active_d  = 1'b1;
            beat_cnt_d  = arlen_q;
            beat_addr_d = araddr_q;
            bst_len_d   = arlen_q;
            bst_size_d  = arsize_q;
            bst_type_d  = arburst_q;
        end

        case (r_st_q)
            ST_WAIT: begin
                if (r_active_q && rvalid_in) begin
                    rdata_d  = rdata_in;
                    rresp_d  = rresp_in;
                    rvalid_d = 1'b1;
                    rlast_d  = (beat_cnt_q == 8'd0);
                    if (rready_in) begin
                        rready_d = 1'b1;
                        r_st_d   = ST_COMMIT;
                    end else begin
                        rready_d = 1'b0;
                        r_st_d   = ST_ASSERT;
                    end
                end
            end
            ST_ASSERT: begin
                if (rready_in) begin
                    rready_d = 1'b1;
                    r_st_d   = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                if (rlast_q) begin
                    r_active_d = 1'b0;
                    rvalid_d   = 1'b0;
                    rready_d   = 1'b0;
                    rlast_d    = 1'b0;
                    r_st_d     = ST_WAIT;
                end else begin
                    beat_cnt_d  = beat_cnt_q - 8'd1;
                    beat_addr_d = next_addr(beat_addr_q, bst_len_q, bst_size_q, bst_type_q);
                    if (rvalid_in) begin
                        rdata_d  = rdata_in;
                        rresp_d  = rresp_in;
                        rvalid_d = 1'b1;
                        rlast_d  = (beat_cnt_q == 8'd1);
                        rready_d = rready_in;
                        r_st_d   = rready_in ? ST_COMMIT : ST_ASSERT;
                    end else begin
                        rvalid_d = 1'b0;
                        rready_d = 1'b0;
                        rlast_d  = 1'b0;
                        r_st_d   = ST_WAIT;
                    end
                end
            end
            default: begin
                rvalid_d = 1'b0;
                rready_d = 1'b0;
                rlast_d  = 1'b0;
                r_st_d   = ST_WAIT;
            end
        endcase

        if (rvalid_in && !r_active_q && (ar_st_q != ST_COMMIT)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge axi_aclk) begin
        if (rst) begin
            ar_st_q     <= ST_WAIT;
            r_st_q      <= ST_WAIT;
            araddr_q    <= '0;
            arlen_q     <= '0;
            arsize_q    <= '0;
            arburst_q   <= '0;
            arvalid_q   <= 1'b0;
            arready_q   <= 1'b0;
            rdata_q     <= '0;
            rresp_q     <= '0;
            rlast_q     <= 1'b0;
            rvalid_q    <= 1'b0;
            rready_q    <= 1'b0;
            bst_len_q   <= '0;
            bst_size_q  <= '0;
            bst_type_q  <= '0;
            beat_cnt_q  <= '0;
            beat_addr_q <= '0;
            r_active_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            ar_st_q     <= ar_st_d;
            r_st_q      <= r_st_d;
            araddr_q    <= araddr_d;
            arlen_q     <= arlen_d;
            arsize_q    <= arsize_d;
            arburst_q   <= arburst_d;
            arvalid_q   <= arvalid_d;
            arready_q   <= arready_d;
            rdata_q     <= rdata_d;
            rresp_q     <= rresp_d;
            rlast_q     <= rlast_d;
            rvalid_q    <= rvalid_d;
            rready_q    <= rready_d;
            bst_len_q   <= bst_len_d;
            bst_size_q  <= bst_size_d;
            bst_type_q  <= bst_type_d;
            beat_cnt_q  <= beat_cnt_d;
            beat_addr_q <= beat_addr_d;
            r_active_q  <= r_active_d;
            err_q       <= err_d;
        end
    end

    assign axi_araddr   = araddr_q;
    assign axi_arlen    = arlen_q;
    assign axi_arsize   = arsize_q;
    assign axi_arburst  = arburst_q;
    assign axi_arvalid  = arvalid_q;
    assign axi_arready  = arready_q;
    assign axi_rdata    = rdata_q;
    assign axi_rresp    = rresp_q;
    assign axi_rlast    = rlast_q;
    assign axi_rvalid   = rvalid_q;
    assign axi_rready   = rready_q;
    assign beat_addr    = beat_addr_q;
    assign r_active     = r_active_q;
    assign err_orphan_r = err_q;

endmodule

// File: tb/tb_axi_read_protocol.sv
// tb/tb_axi_read_protocol.sv - self-checking bench for axi_read_protocol
// Cycle vector table plus hand-written burst sequences with a beat scoreboard.
module tb_axi_read_protocol;

    localparam int AW = 32;
    localparam int DW = 64;

    logic          axi_aclk = 1'b0;
    logic          rst;
    logic [AW-1:0] araddr_in;
    logic [7:0]    arlen_in;
    logic [2:0]    arsize_in;
    logic [1:0]    arburst_in;
    logic          arvalid_in;
    logic          arready_in;
    logic [DW-1:0] rdata_in;
    logic [1:0]    rresp_in;
    logic          rvalid_in;
    logic          rready_in;
    logic [AW-1:0] axi_araddr;
    logic [7:0]    axi_arlen;
    logic [2:0]    axi_arsize;
    logic [1:0]    axi_arburst;
    logic          axi_arvalid;
    logic          axi_arready;
    logic [DW-1:0] axi_rdata;
    logic [1:0]    axi_rresp;
    logic          axi_rlast;
    logic          axi_rvalid;
    logic          axi_rready;
    logic [AW-1:0] beat_addr;
    logic          r_active;
    logic          err_orphan_r;
    logic          any_out;

    always #5 axi_aclk = ~axi_aclk;

    axi_read_protocol #(.AW(AW), .DW(DW)) dut (
        .axi_aclk(axi_aclk), .rst(rst),
        .araddr_in(araddr_in), .arlen_in(arlen_in), .arsize_in(arsize_in), .arburst_in(arburst_in),
        .arvalid_in(arvalid_in), .arready_in(arready_in),
        .rdata_in(rdata_in), .rresp_in(rresp_in), .rvalid_in(rvalid_in), .rready_in(rready_in),
        .axi_araddr(axi_araddr), .axi_arlen(axi_arlen), .axi_arsize(axi_arsize), .axi_arburst(axi_arburst),
        .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
        .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rlast(axi_rlast),
        .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
        .beat_addr(beat_addr), .r_active(r_active), .err_orphan_r(err_orphan_r)
    );

    assign any_out = |{axi_araddr, axi_arlen, axi_arsize, axi_arburst, axi_arvalid, axi_arready,
                       axi_rdata, axi_rresp, axi_rlast, axi_rvalid, axi_rready, beat_addr,
                       r_active, err_orphan_r};

    int n_cmp = 0;
    int n_err = 0;

    // in flags {rst,arv,arr,rv,rr}; expected flags {arv,arr,rv,rr,rlast,r_active,err}
    typedef struct {
        logic [4:0]  fin;
        logic [31:0] addr;
        logic [63:0] data;
        logic [6:0]  fexp;
        logic [31:0] e_araddr;
        logic [63:0] e_data;
        logic [31:0] e_ba;
    } vec_t;

    typedef struct {
        logic [63:0] data;
        logic [31:0] addr;
        logic        last;
    } beat_t;

    vec_t  vec_q[$];
    beat_t beat_q[$];
    bit    mon_en = 1'b0;

    function automatic vec_t mk(input logic [4:0] fin, input logic [31:0] addr, input logic [63:0] data,
                                input logic [6:0] fexp, input logic [31:0] e_araddr,
                                input logic [63:0] e_data, input logic [31:0] e_ba);
        vec_t v;
        v.fin = fin; v.addr = addr; v.data = data;
        v.fexp = fexp; v.e_araddr = e_araddr; v.e_data = e_data; v.e_ba = e_ba;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic step();
        beat_t b;
        @(posedge axi_aclk);
        #1;
        if (mon_en && axi_rvalid && axi_rready) begin
            if (beat_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL beat_unexpected: got rdata %h want no transfer", axi_rdata);
            end else begin
                b = beat_q.pop_front();
                chk("beat_data", axi_rdata, b.data);
                chk("beat_addr", 64'(beat_addr), 64'(b.addr));
                chk("beat_last", 64'(axi_rlast), 64'(b.last));
            end
        end
    endtask

    task automatic set_ar(input logic v, input logic r, input logic [31:0] a, input logic [7:0] l,
                          input logic [2:0] s, input logic [1:0] bt);
        arvalid_in = v; arready_in = r; araddr_in = a; arlen_in = l; arsize_in = s; arburst_in = bt;
    endtask

    task automatic set_r(input logic v, input logic r, input logic [63:0] d);
        rvalid_in = v; rready_in = r; rdata_in = d; rresp_in = d[1:0];
    endtask

    task automatic push_beat(input logic [63:0] d, input logic [31:0] a, input logic l);
        beat_t b;
        b.data = d; b.addr = a; b.last = l;
        beat_q.push_back(b);
    endtask

    task automatic burst_ar(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s, input logic [1:0] bt);
        set_ar(1'b1, 1'b1, a, l, s, bt);
        step();
        chk("ar_handshake", 64'({axi_arvalid, axi_arready}), 64'(2'b11));
        set_ar(1'b0, 1'b0, a, l, s, bt);
        step();
        chk("ar_active", 64'({r_active, axi_arvalid, axi_arready}), 64'(3'b100));
        chk("ar_start_addr", 64'(beat_addr), 64'(a));
    endtask

    task automatic finish_burst(input string nm);
        set_r(1'b0, 1'b0, 64'h0);
        step();
        chk({nm, "_done"}, 64'({r_active, axi_rvalid, axi_rready, axi_rlast}), 64'(4'b0000));
        chk({nm, "_drained"}, 64'(beat_q.size()), 64'(0));
    endtask

    initial begin
        vec_t          tv[18];
        vec_t          v;
        logic [31:0]   wexp[4];

        rst = 1'b1;
        set_ar(1'b0, 1'b0, 32'h0, 8'd0, 3'd0, 2'b00);
        set_r(1'b0, 1'b0, 64'h0);

        tv[0]  = mk(5'b10000, 32'h00, 64'h00, 7'b0000000, 32'h00, 64'h00, 32'h00);
        tv[1]  = mk(5'b01100, 32'h40, 64'h00, 7'b1100000, 32'h40, 64'h00, 32'h00);
        tv[2]  = mk(5'b00000, 32'h40, 64'h00, 7'b0000010, 32'h40, 64'h00, 32'h40);
        tv[3]  = mk(5'b00011, 32'h40, 64'hAA, 7'b0011110, 32'h40, 64'hAA, 32'h40);
        tv[4]  = mk(5'b00000, 32'h40, 64'h00, 7'b0000000, 32'h40, 64'hAA, 32'h40);
        tv[5]  = mk(5'b00011, 32'h40, 64'h55, 7'b0000001, 32'h40, 64'hAA, 32'h40);
        tv[6]  = mk(5'b00000, 32'h40, 64'h00, 7'b0000001, 32'h40, 64'hAA, 32'h40);
        tv[7]  = mk(5'b10000, 32'h00, 64'h00, 7'b0000000, 32'h00, 64'h00, 32'h00);
        tv[8]  = mk(5'b01000, 32'h80, 64'h00, 7'b1000000, 32'h80, 64'h00, 32'h00);
        tv[9]  = mk(5'b01100, 32'h80, 64'h00, 7'b1100000, 32'h80, 64'h00, 32'h00);
        tv[10] = mk(5'b00000, 32'h80, 64'h00, 7'b0000010, 32'h80, 64'h00, 32'h80);
        tv[11] = mk(5'b00010, 32'h80, 64'h11, 7'b0010110, 32'h80, 64'h11, 32'h80);
        tv[12] = mk(5'b00011, 32'h80, 64'h99, 7'b0011110, 32'h80, 64'h11, 32'h80);
        tv[13] = mk(5'b00000, 32'h80, 64'h00, 7'b0000000, 32'h80, 64'h11, 32'h80);
        tv[14] = mk(5'b01100, 32'hC0, 64'h00, 7'b1100000, 32'hC0, 64'h11, 32'h80);
        tv[15] = mk(5'b00010, 32'hC0, 64'h33, 7'b0000010, 32'hC0, 64'h11, 32'hC0);
        tv[16] = mk(5'b00011, 32'hC0, 64'h22, 7'b0011110, 32'hC0, 64'h22, 32'hC0);
        tv[17] = mk(5'b00000, 32'hC0, 64'h00, 7'b0000000, 32'hC0, 64'h22, 32'hC0);

        for (int i = 0; i < 18; i++) begin
            rst = tv[i].fin[4];
            set_ar(tv[i].fin[3], tv[i].fin[2], tv[i].addr, 8'd0, 3'd3, 2'b01);
            set_r(tv[i].fin[1], tv[i].fin[0], tv[i].data);
            vec_q.push_back(tv[i]);
            step();
            v = vec_q.pop_front();
            chk($sformatf("vec%0d_flags", i),
                64'({axi_arvalid, axi_arready, axi_rvalid, axi_rready, axi_rlast, r_active, err_orphan_r}),
                64'(v.fexp));
            chk($sformatf("vec%0d_araddr", i), 64'(axi_araddr), 64'(v.e_araddr));
            chk($sformatf("vec%0d_rdata", i), axi_rdata, v.e_data);
            chk($sformatf("vec%0d_rresp", i), 64'(axi_rresp), 64'(v.e_data[1:0]));
            chk($sformatf("vec%0d_beat_addr", i), 64'(beat_addr), 64'(v.e_ba));
        end
        rst = 1'b0;

        // INCR burst streamed back to back
        burst_ar(32'h100, 8'd3, 3'd3, 2'b01);
        for (int i = 0; i < 4; i++) push_beat(64'hD000 + 64'(i), 32'h100 + 32'(8 * i), i == 3);
        mon_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_r(1'b1, 1'b1, 64'hD000 + 64'(i));
            step();
            chk("incr_no_bubble", 64'({axi_rvalid, axi_rready}), 64'(2'b11));
        end
        finish_burst("incr");

        // WRAP burst
        wexp[0] = 32'h38; wexp[1] = 32'h20; wexp[2] = 32'h28; wexp[3] = 32'h30;
        burst_ar(32'h38, 8'd3, 3'd3, 2'b10);
        for (int i = 0; i < 4; i++) push_beat(64'hE000 + 64'(i), wexp[i], i == 3);
        for (int i = 0; i < 4; i++) begin
            set_r(1'b1, 1'b1, 64'hE000 + 64'(i));
            step();
        end
        finish_burst("wrap");

        // Backpressure mid-burst: rready_in low for three cycles
        burst_ar(32'h200, 8'd3, 3'd2, 2'b01);
        push_beat(64'hF000, 32'h200, 1'b0);
        push_beat(64'hF001, 32'h204, 1'b0);
        push_beat(64'hF002, 32'h208, 1'b0);
        push_beat(64'hF003, 32'h20C, 1'b1);
        set_r(1'b1, 1'b1, 64'hF000);
        step();
        for (int i = 0; i < 3; i++) begin
            set_r(1'b1, 1'b0, (i == 0) ? 64'hF001 : 64'hBAD0);
            step();
            chk("bp_hold_flags", 64'({axi_rvalid, axi_rready, axi_rlast}), 64'(3'b100));
            chk("bp_hold_data", axi_rdata, 64'hF001);
            chk("bp_hold_addr", 64'(beat_addr), 64'h204);
        end
        set_r(1'b1, 1'b1, 64'hBAD1);
        step();
        set_r(1'b1, 1'b1, 64'hF002);
        step();
        set_r(1'b1, 1'b1, 64'hF003);
        step();
        finish_burst("bp");

        // Second AR held during a burst
        set_ar(1'b1, 1'b1, 32'h400, 8'd1, 3'd3, 2'b01);
        step();
        chk("ar2_first_hs", 64'({axi_arvalid, axi_arready}), 64'(2'b11));
        set_ar(1'b1, 1'b1, 32'h500, 8'd0, 3'd3, 2'b01);
        step();
        chk("ar2_queued", 64'({axi_arvalid, axi_arready, r_active}), 64'(3'b101));
        chk("ar2_payload", 64'(axi_araddr), 64'h500);
        chk("ar2_first_addr", 64'(beat_addr), 64'h400);
        push_beat(64'hA0, 32'h400, 1'b0);
        push_beat(64'hA1, 32'h408, 1'b1);
        set_r(1'b1, 1'b1, 64'hA0);
        step();
        chk("ar2_blocked0", 64'({axi_arvalid, axi_arready}), 64'(2'b10));
        set_r(1'b1, 1'b1, 64'hA1);
        step();
        chk("ar2_blocked1", 64'({axi_arvalid, axi_arready}), 64'(2'b10));
        set_r(1'b0, 1'b0, 64'h0);
        step();
        chk("ar2_release", 64'({axi_arvalid, axi_arready, r_active}), 64'(3'b100));
        step();
        chk("ar2_commit", 64'({axi_arvalid, axi_arready, r_active}), 64'(3'b110));
        set_ar(1'b0, 1'b0, 32'h500, 8'd0, 3'd3, 2'b01);
        step();
        chk("ar2_active", 64'({r_active, axi_arvalid}), 64'(2'b10));
        chk("ar2_start_addr", 64'(beat_addr), 64'h500);
        push_beat(64'hA2, 32'h500, 1'b1);
        set_r(1'b1, 1'b1, 64'hA2);
        step();
        finish_burst("ar2");
        mon_en = 1'b0;

        // Reset mid-burst aborts silently, later beats are orphans
        burst_ar(32'h600, 8'd3, 3'd3, 2'b01);
        set_r(1'b1, 1'b0, 64'hC0);
        step();
        chk("rst_pre_assert", 64'({axi_rvalid, axi_rready, r_active}), 64'(3'b101));
        rst = 1'b1;
        set_r(1'b1, 1'b1, 64'hC1);
        step();
        chk("rst_all_zero", 64'(any_out), 64'(0));
        rst = 1'b0;
        set_r(1'b0, 1'b0, 64'h0);
        step();
        chk("rst_still_zero", 64'(any_out), 64'(0));
        set_r(1'b1, 1'b1, 64'hC2);
        step();
        chk("orphan_after_rst", 64'({err_orphan_r, axi_rvalid, r_active}), 64'(3'b100));
        set_r(1'b0, 1'b0, 64'h0);
        step();
        chk("orphan_sticky", 64'(err_orphan_r), 64'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
